// File: rtl/sequencia_jogo_param_if.sv
// Board I/O and sequence-ROM bus of the game sequencer.
// The slave modport is the sequencer; the master modport is the board/ROM side.
interface sequencia_jogo_param_if #(
  parameter int N_BTN   = 4,
  parameter int ADDR_W  = 4,
  parameter int ERR_W   = 2,
  parameter int SCORE_W = 8
);
  logic               jogar;
  logic [N_BTN-1:0]   botoes;
  logic [N_BTN-1:0]   mem_data;
  logic [ADDR_W-1:0]  mem_addr;
  logic [N_BTN-1:0]   leds;
  logic [ADDR_W-1:0]  rodada;
  logic [ERR_W-1:0]   erros;
  logic [SCORE_W-1:0] pontos;
  logic               pronto;
  logic               acertou;
  logic               timeout_flag;
  logic [4:0]         db_estado;

  modport master (
    output jogar, botoes, mem_data,
    input  mem_addr, leds, rodada, erros, pontos, pronto, acertou, timeout_flag, db_estado
  );

  modport slave (
    input  jogar, botoes, mem_data,
    output mem_addr, leds, rodada, erros, pontos, pronto, acertou, timeout_flag, db_estado
  );
endinterface

// File: rtl/sequencia_jogo_param.sv
// Parametrised game sequencer: plays a growing LED sequence from an external ROM,
// checks one-hot button presses, allows retries per round and keeps a saturating score.
//
// state     | meaning
// IDLE      | waiting for jogar
// PREP      | clear counters and score for a new game
// SHOW      | light ROM entry at addr for T_LED cycles
// GAP       | all LEDs dark for T_GAP cycles
// WAIT      | waiting for a press, T_TIMEOUT cycles allowed
// CHECK     | compare latched press against ROM entry
// NEXT      | advance to the next expected entry
// ERR       | count a wrong press, replay or lose
// ROUND_END | add round points, next round or win
// WIN       | all rounds done
// LOSE_TO   | press timeout
// LOSE_ERR  | error limit reached
module sequencia_jogo_param #(
  parameter int N_BTN     = 4,
  parameter int N_ROUNDS  = 16,
  parameter int ADDR_W    = 4,
  parameter int T_LED     = 1000,
  parameter int T_GAP     = 250,
  parameter int T_TIMEOUT = 5000,
  parameter int MAX_ERR   = 3,
  parameter int PTS_ROUND = 10,
  parameter int PEN       = 3,
  parameter int SCORE_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  sequencia_jogo_param_if.slave bus
);
  localparam int ERR_W     = $clog2(MAX_ERR + 1);
  localparam int T_MAX     = (T_LED > T_GAP) ? ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT)
                                             : ((T_GAP > T_TIMEOUT) ? T_GAP : T_TIMEOUT);
  localparam int TMR_W     = $clog2(T_MAX + 1);
  localparam int SCORE_MAX = (2 ** SCORE_W) - 1;

  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    PREP      = 5'd1,
    SHOW      = 5'd2,
    GAP       = 5'd3,
    WAIT      = 5'd4,
    CHECK     = 5'd5,
    NEXT      = 5'd6,
    ERR       = 5'd7,
    ROUND_END = 5'd8,
    WIN       = 5'd9,
    LOSE_TO   = 5'd10,
    LOSE_ERR  = 5'd11
  } state_t;

  state_t             state, stateNext;
  logic [TMR_W-1:0]   timer, timerLoad;
  logic [ADDR_W-1:0]  addr, limit;
  logic [ERR_W-1:0]   erros;
  logic [SCORE_W-1:0] pontos, pontosSum;
  logic [N_BTN-1:0]   btnPrev, btnLatch;
  logic               press, tDone, lastEntry, lastRound, hit, errLimit;
  int                 gain, sum;

  assign press     = (bus.botoes != '0) && (btnPrev == '0);
  assign tDone     = (timer == '0);
  assign lastEntry = (addr == limit);
  assign lastRound = (limit == ADDR_W'(N_ROUNDS - 1));
  assign hit       = (btnLatch == bus.mem_data);
  assign errLimit  = ((int'(erros) + 1) == MAX_ERR);

  // Round gain never goes negative; total clamps at the top of the score range.
  always_comb begin
    gain = PTS_ROUND - PEN * int'(erros);
    if (gain < 0) gain = 0;
    sum = int'(pontos) + gain;
    pontosSum = (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (bus.jogar) stateNext = PREP;
      PREP:      stateNext = SHOW;
      SHOW:      if (tDone) stateNext = GAP;
      GAP:       if (tDone) stateNext = lastEntry ? WAIT : SHOW;
      WAIT: begin
        if (tDone)      stateNext = LOSE_TO;
        else if (press) stateNext = CHECK;
      end
      CHECK: begin
        if (!hit)           stateNext = ERR;
        else if (lastEntry) stateNext = ROUND_END;
        else                stateNext = NEXT;
      end
      NEXT:      stateNext = WAIT;
      ERR:       stateNext = errLimit ? LOSE_ERR : SHOW;
      ROUND_END: stateNext = lastRound ? WIN : SHOW;
      WIN, LOSE_TO, LOSE_ERR: if (bus.jogar) stateNext = PREP;
      default:   stateNext = IDLE;
    endcase
  end

  // Down-counter reloaded on every state change; zero marks the last cycle of a phase.
  always_comb begin
    timerLoad = '0;
    case (stateNext)
      SHOW:    timerLoad = TMR_W'(T_LED - 1);
      GAP:     timerLoad = TMR_W'(T_GAP - 1);
      WAIT:    timerLoad = TMR_W'(T_TIMEOUT - 1);
      default: timerLoad = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer    <= '0;
      addr     <= '0;
      limit    <= '0;
      erros    <= '0;
      pontos   <= '0;
      btnPrev  <= '0;
      btnLatch <= '0;
    end else begin
      btnPrev <= bus.botoes;
      if (press) btnLatch <= bus.botoes;
      if (stateNext != state) timer <= timerLoad;
      else if (!tDone)        timer <= timer - TMR_W'(1);
      case (state)
        PREP: begin
          addr   <= '0;
          limit  <= '0;
          erros  <= '0;
          pontos <= '0;
        end
        GAP:  if (tDone) addr <= lastEntry ? '0 : addr + ADDR_W'(1);
        NEXT: addr <= addr + ADDR_W'(1);
        ERR: begin
          erros <= erros + ERR_W'(1);
          addr  <= '0;
        end
        ROUND_END: begin
          pontos <= pontosSum;
          if (!lastRound) begin
            limit <= limit + ADDR_W'(1);
            addr  <= '0;
            erros <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.leds = '0;
    case (state)
      SHOW:    bus.leds = bus.mem_data;
      WAIT:    bus.leds = bus.botoes;
      default: bus.leds = '0;
    endcase
  end

  assign bus.mem_addr     = addr;
  assign bus.rodada       = limit;
  assign bus.erros        = erros;
  assign bus.pontos       = pontos;
  assign bus.pronto       = (state == WIN) || (state == LOSE_TO) || (state == LOSE_ERR);
  assign bus.acertou      = (state == WIN);
  assign bus.timeout_flag = (state == LOSE_TO);
  assign bus.db_estado    = state;
endmodule
